// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file constants and helpers for the write-back path.
package rf_wb_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;
  localparam int CNT_W = 16;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_picker.sv
// Round-robin priority picker: first valid index at or after ptr, wrapping.
module rr_picker
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && valid[PTR_W'(cand)]) begin
        found = 1'b1;
        grant[PTR_W'(cand)] = 1'b1;
        idx = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant, one registered write per cycle.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [RF_ADDR_W*NREQ-1:0] req_addr,
  input  logic [RF_DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      WE,
  output logic [RF_ADDR_W-1:0]      WDA,
  output logic [RF_DATA_W-1:0]      WD,
  output logic [CNT_W-1:0]          grant_cnt
);

  localparam int PTR_W = ptr_width(NREQ);

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic [NREQ-1:0]      gnt;
  logic                 gnt_found;
  logic                 accept;
  logic [RF_ADDR_W-1:0] sel_addr;
  logic [RF_DATA_W-1:0] sel_data;

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .found (gnt_found)
  );

  always_comb begin
    accept    = gnt_found && !hold && !reset;
    req_ready = accept ? gnt : '0;
    ptr_next  = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // One-hot grant mux avoids a variable-width part-select on the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
        sel_data = req_data[i*RF_DATA_W +: RF_DATA_W];
      end
    end
  end

  // Writes to the zero register are consumed and counted but never enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WE        <= 1'b0;
      WDA       <= '0;
      WD        <= '0;
      grant_cnt <= '0;
      ptr       <= '0;
    end else begin
      WE <= accept && (sel_addr != RF_ZERO_REG);
      if (accept) begin
        WDA       <= sel_addr;
        WD        <= sel_data;
        ptr       <= ptr_next;
        grant_cnt <= grant_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table, directed corner cases, random vs model.
module tb_rf_wb_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_addr;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            WE;
  logic [4:0]      WDA;
  logic [31:0]     WD;
  logic [15:0]     grant_cnt;

  rf_wb_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .WE        (WE),
    .WDA       (WDA),
    .WD        (WD),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port.
  logic [31:0] rf [32];
  always @(posedge clk) if (WE) rf[WDA] <= WD;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_wda;
  logic [31:0] m_wd;
  int          m_cnt;

  typedef struct {
    bit           hold;
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_wda = '0; m_wd = '0; m_cnt = 0;
  endtask

  function automatic int model_grant();
    int j;
    if (hold) return -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  // Called just after inputs are driven (active edge + 1).
  task automatic step(input string tag, output int g);
    logic [N-1:0] exp_ready;
    #1;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
    if (g >= 0) begin
      m_wda = req_addr[g*5 +: 5];
      m_wd  = req_data[g*32 +: 32];
      m_we  = (m_wda != 0);
      m_cnt = (m_cnt + 1) % 65536;
      m_ptr = (g + 1) % N;
    end else begin
      m_we = 0;
    end
    @(posedge clk); #1;
    chk({tag, ".WE"},  32'(WE),        32'(m_we));
    chk({tag, ".WDA"}, 32'(WDA),       32'(m_wda));
    chk({tag, ".WD"},  WD,             m_wd);
    chk({tag, ".cnt"}, 32'(grant_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '1;
    hold = 1'b0;
    #1;
    chk("rst.WE",    32'(WE),        0);
    chk("rst.WDA",   32'(WDA),       0);
    chk("rst.WD",    WD,             0);
    chk("rst.cnt",   32'(grant_cnt), 0);
    chk("rst.ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  initial begin
    int g;
    int remaining;
    logic [N-1:0] last_acc;

    tbl[0]  = '{0, 3'b111, 3'b001};
    tbl[1]  = '{0, 3'b111, 3'b010};
    tbl[2]  = '{0, 3'b111, 3'b100};
    tbl[3]  = '{0, 3'b111, 3'b001};
    tbl[4]  = '{0, 3'b111, 3'b010};
    tbl[5]  = '{0, 3'b111, 3'b100};
    tbl[6]  = '{1, 3'b111, 3'b000};
    tbl[7]  = '{1, 3'b111, 3'b000};
    tbl[8]  = '{0, 3'b110, 3'b010};
    tbl[9]  = '{0, 3'b011, 3'b001};
    tbl[10] = '{0, 3'b000, 3'b000};
    tbl[11] = '{0, 3'b101, 3'b100};
    tbl[12] = '{0, 3'b010, 3'b010};
    tbl[13] = '{0, 3'b010, 3'b010};

    reset = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    @(posedge clk); #1;
    do_reset();

    // Single requester 1: granted the same cycle, written the next.
    req_valid = 3'b010;
    req_addr[5 +: 5] = 5'd7;
    req_data[32 +: 32] = 32'hDEADBEEF;
    step("single", g);
    chk("single.WE_const",  32'(WE), 1);
    chk("single.WDA_const", 32'(WDA), 7);
    chk("single.WD_const",  WD, 32'hDEADBEEF);

    do_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[i*5 +: 5]   = 5'(3 + i);
      req_data[i*32 +: 32] = 32'h100 + 32'(i);
    end
    for (int i = 0; i < 14; i++) begin
      hold = tbl[i].hold;
      req_valid = tbl[i].valid;
      #1;
      chk($sformatf("tbl%0d.ready_const", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      step($sformatf("tbl%0d", i), g);
      if (i == 5) chk("rr6.cnt_const", 32'(grant_cnt), 6);
    end

    // Zero-register write: consumed and counted, no enable.
    hold = 1'b0;
    req_valid = 3'b001;
    req_addr[0 +: 5] = 5'd0;
    req_data[0 +: 32] = 32'h12345678;
    step("zero", g);
    chk("zero.WE_const", 32'(WE), 0);

    // Hold while a write sits in the output register.
    req_addr[0 +: 5] = 5'd4;
    req_valid = 3'b111;
    step("prehold", g);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i), g);
    hold = 1'b0;
    step("unhold", g);

    // Same address from two requesters: grant order decides the final value.
    do_reset();
    req_addr[0 +: 5] = 5'd9;  req_data[0 +: 32]  = 32'h1;
    req_addr[10 +: 5] = 5'd9; req_data[64 +: 32] = 32'h2;
    req_valid = 3'b101;
    step("same0", g);
    chk("same0.WD_const", WD, 32'h1);
    req_valid = 3'b100;
    step("same1", g);
    chk("same1.WD_const", WD, 32'h2);
    req_valid = 3'b000;
    step("same2", g);
    step("same3", g);
    chk("same.rf9", rf[9], 32'h2);

    // Reset one cycle after an accept drops the pending write.
    req_addr[0 +: 5] = 5'd5;
    req_data[0 +: 32] = 32'h55;
    req_valid = 3'b001;
    step("prerst", g);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst.WE",  32'(WE), 0);
    chk("midrst.WDA", 32'(WDA), 0);
    chk("midrst.WD",  WD, 0);
    chk("midrst.cnt", 32'(grant_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    req_valid = 3'b111;
    #1;
    chk("postrst.ready_const", 32'(req_ready), 1);
    step("postrst", g);

    // Random traffic; requesters keep a request stable until it is accepted.
    last_acc = '0;
    req_valid = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_acc[i] && ($urandom % 2 == 0)) req_valid[i] = 1'b0;
        if (!req_valid[i] || last_acc[i]) begin
          if ($urandom % 3 != 0) begin
            req_valid[i] = 1'b1;
            req_addr[i*5 +: 5] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            req_data[i*32 +: 32] = $urandom;
          end
        end
      end
      hold = ($urandom % 5 == 0);
      step("rand", g);
      last_acc = '0;
      if (g >= 0) last_acc[g] = 1'b1;
    end

    // Drive the accept counter through its wrap point.
    hold = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_addr[i*5 +: 5] = 5'(i + 1);
    remaining = 65535 - m_cnt;
    for (int i = 0; i < remaining; i++) step("fill", g);
    chk("wrap.pre", 32'(grant_cnt), 32'hFFFF);
    step("wrap", g);
    chk("wrap.post", 32'(grant_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
